// File: rtl/keccak_pkg.sv
// Shared Keccak lane-level definitions: geometry, lane types, the rho offset
// table used by both the forward and inverse steps, and lane rotation helpers.
package keccak_pkg;

  localparam int unsigned LANE_SIZE = 64;
  localparam int unsigned ROW_SIZE  = 5;
  localparam int unsigned COL_SIZE  = 5;
  localparam int unsigned NUM_LANES = ROW_SIZE * COL_SIZE;

  typedef logic [LANE_SIZE-1:0] lane_t;
  typedef logic [4:0]           lane_idx_t;

  // Indexed [x][y]; lane index is 5x + y.
  localparam int unsigned RHO_OFFSETS [ROW_SIZE][COL_SIZE] = '{
    '{ 0, 36,  3, 41, 18},
    '{ 1, 44, 10, 45,  2},
    '{62,  6, 43, 15, 61},
    '{28, 55, 25, 21, 56},
    '{27, 20, 39,  8, 14}
  };

  // Offset 0 returns early so no shift by LANE_SIZE is ever produced.
  function automatic lane_t lane_rotr(lane_t a, int unsigned off);
    int unsigned r;
    r = off % LANE_SIZE;
    if (r == 0) return a;
    return (a >> r) | (a << (LANE_SIZE - r));
  endfunction

  function automatic lane_t lane_rotl(lane_t a, int unsigned off);
    int unsigned r;
    r = off % LANE_SIZE;
    return lane_rotr(a, (LANE_SIZE - r) % LANE_SIZE);
  endfunction

endpackage

// File: rtl/rho_inv_lane.sv
// Combinational inverse-rho for a single lane: right-rotates by the rho
// offset of the given lane index, built as a mux over constant rotations.
module rho_inv_lane
  import keccak_pkg::*;
(
  input  logic [LANE_SIZE-1:0] lane,
  input  logic [4:0]           idx,
  output logic [LANE_SIZE-1:0] rot_lane
);

  lane_t rot [NUM_LANES];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_rot
    assign rot[g] = lane_rotr(lane, RHO_OFFSETS[g / COL_SIZE][g % COL_SIZE]);
  end

  always_comb begin
    rot_lane = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (idx == lane_idx_t'(i)) rot_lane = rot[i];
    end
  end

endmodule

// File: rtl/rho_inv_stream.sv
// Lane-serial inverse rho: one lane per beat in x-major order, rotated and
// presented through a single registered valid/ready stage with framing check.
module rho_inv_stream
  import keccak_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [LANE_SIZE-1:0] in_lane_i,
  input  logic                 in_last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [LANE_SIZE-1:0] out_lane_o,
  output logic [4:0]           out_idx_o,
  output logic                 out_last_o,
  output logic                 err_o
);

  localparam lane_idx_t LAST_IDX = lane_idx_t'(NUM_LANES - 1);

  lane_idx_t cnt;
  lane_t     rot_lane;
  logic      accept;
  logic      cnt_at_end;
  logic      frame_err;

  rho_inv_lane u_rot (
    .lane     (in_lane_i),
    .idx      (cnt),
    .rot_lane (rot_lane)
  );

  assign in_ready_o = !flush_i && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign cnt_at_end = (cnt == LAST_IDX);
  assign frame_err  = in_last_i ^ cnt_at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      out_valid_o <= 1'b0;
      out_lane_o  <= '0;
      out_idx_o   <= '0;
      out_last_o  <= 1'b0;
      err_o       <= 1'b0;
    end else if (flush_i) begin
      cnt         <= '0;
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      err_o       <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      out_lane_o  <= rot_lane;
      out_idx_o   <= cnt;
      out_last_o  <= cnt_at_end;
      err_o       <= frame_err;
      // A sender-marked last always resyncs; a missing last still wraps.
      cnt         <= (in_last_i || cnt_at_end) ? '0 : cnt + 5'd1;
    end else begin
      err_o <= 1'b0;
      if (out_ready_i) out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rho_inv_stream.sv
// Self-checking bench for rho_inv_stream: directed spot checks plus a
// cycle-level reference model with offsets derived from the Keccak t-walk.
module tb_rho_inv_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_lane = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_lane;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        err;

  int errors = 0;
  int checks = 0;

  bit          bp_mode = 0;
  bit          rt_mode = 0;
  logic [63:0] rt_q[$];
  int          rt_n = 0;

  // reference model state (registered outputs as they should be after the last edge)
  bit          m_valid = 0;
  logic [63:0] m_lane = '0;
  int          m_idx = 0;
  bit          m_last = 0;
  bit          m_err = 0;
  int          m_cnt = 0;

  rho_inv_stream dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_lane_i   (in_lane),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_lane_o  (out_lane),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Rho offset from the Keccak definition: walk (x,y) from (1,0), offset (t+1)(t+2)/2.
  function automatic int off_ref(input int idx);
    int x = 1, y = 0, nx;
    if (idx == 0) return 0;
    for (int t = 0; t < 24; t++) begin
      if (5 * x + y == idx) return ((t + 1) * (t + 2) / 2) % 64;
      nx = y;
      y  = (2 * x + 3 * y) % 5;
      x  = nx;
    end
    return 0;
  endfunction

  function automatic logic [63:0] rotr_ref(input logic [63:0] a, input int r);
    logic [127:0] d;
    d = {a, a} >> r;
    return d[63:0];
  endfunction

  function automatic logic [63:0] rotl_ref(input logic [63:0] a, input int r);
    return rotr_ref(a, (64 - r) % 64);
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    bit exp_ready;
    if (rst) begin
      m_valid = 0; m_lane = '0; m_idx = 0; m_last = 0; m_err = 0; m_cnt = 0;
    end
    check_eq("out_valid", out_valid, m_valid);
    check_eq("err", err, m_err);
    if (m_valid || rst) begin
      check_eq("out_lane", out_lane, m_lane);
      check_eq("out_idx", out_idx, m_idx);
      check_eq("out_last", out_last, m_last);
    end
    exp_ready = !flush && (!m_valid || out_ready);
    check_eq("in_ready", in_ready, exp_ready);
    if (rt_mode && out_valid && out_ready) begin
      if (rt_q.size() == 0) check_eq("rt_extra_beat", 1, 0);
      else begin
        check_eq("rt_lane", out_lane, rt_q.pop_front());
        check_eq("rt_idx", out_idx, rt_n % 25);
        rt_n++;
      end
    end
    if (!rst) begin
      if (flush) begin
        m_cnt = 0; m_valid = 0; m_last = 0; m_err = 0;
      end else if (in_valid && exp_ready) begin
        m_lane  = rotr_ref(in_lane, off_ref(m_cnt));
        m_idx   = m_cnt;
        m_last  = (m_cnt == 24);
        m_valid = 1;
        m_err   = (in_last != (m_cnt == 24));
        m_cnt   = (in_last || m_cnt == 24) ? 0 : m_cnt + 1;
      end else begin
        m_err = 0;
        if (out_ready) m_valid = 0;
      end
    end
  end

  task automatic cycle(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] lane, input bit last, output bit ok);
    bit acc;
    int n = 0;
    in_valid = 1; in_lane = lane; in_last = last;
    do begin
      if (bp_mode) out_ready = 1'($urandom_range(0, 1));
      cycle(acc);
      n++;
    end while (!acc && n < 100);
    in_valid = 0; in_last = 0;
    ok = acc;
    if (!acc) check_eq("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 0;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  initial begin
    bit ok, acc;
    logic [63:0] orig, lane;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_lane", out_lane, 0);
    rst = 0;
    idle(1);

    // 1: single state, directed lanes
    for (int k = 0; k < 25; k++) begin
      lane = (k == 0) ? 64'hDEAD_BEEF_0123_4567 : (k == 1) ? 64'h0000_0010_0000_0000 :
             (k == 24) ? 64'h0000_0000_0000_4000 : rand64();
      send_beat(lane, k == 24, ok);
      if (k == 0) check_eq("t1_lane0", out_lane, 64'hDEAD_BEEF_0123_4567);
      if (k == 1) check_eq("t1_lane1", out_lane, 64'h1);
      if (k == 24) begin
        check_eq("t1_lane24", out_lane, 64'h1);
        check_eq("t1_last24", out_last, 1);
      end
    end
    idle(2);

    // 2: round trip through forward rho
    rt_mode = 1;
    for (int s = 0; s < 100; s++)
      for (int k = 0; k < 25; k++) begin
        orig = rand64();
        send_beat(rotl_ref(orig, off_ref(k)), k == 24, ok);
        if (ok) rt_q.push_back(orig);
      end
    idle(3);
    check_eq("rt_leftover", rt_q.size(), 0);
    check_eq("rt_count", rt_n, 2500);
    rt_mode = 0;

    // 3: random backpressure
    bp_mode = 1;
    for (int s = 0; s < 10; s++)
      for (int k = 0; k < 25; k++) send_beat(rand64(), k == 24, ok);
    bp_mode = 0;
    out_ready = 1;
    idle(3);

    // 4: framing errors
    for (int k = 0; k <= 10; k++) send_beat(rand64(), k == 10, ok);
    check_eq("t4_err_early", err, 1);
    check_eq("t4_err_idx", out_idx, 10);
    idle(1);
    check_eq("t4_err_pulse", err, 0);
    for (int k = 0; k < 25; k++) begin
      send_beat(rand64(), 0, ok);
      if (k == 0) check_eq("t4_resync_idx", out_idx, 0);
      if (k == 0) check_eq("t4_resync_err", err, 0);
    end
    check_eq("t4_err_missing", err, 1);
    check_eq("t4_missing_idx", out_idx, 24);
    send_beat(rand64(), 0, ok);
    check_eq("t4_wrap_idx", out_idx, 0);
    for (int k = 1; k < 25; k++) send_beat(rand64(), k == 24, ok);
    idle(2);

    // 5: flush mid-state with a stalled output
    for (int k = 0; k < 8; k++) send_beat(rand64(), 0, ok);
    out_ready = 0;
    idle(1);
    check_eq("t5_stall_valid", out_valid, 1);
    check_eq("t5_stall_idx", out_idx, 7);
    flush = 1; out_ready = 1; in_valid = 1; in_lane = rand64();
    #1;
    check_eq("t5_flush_ready", in_ready, 0);
    cycle(acc);
    flush = 0; in_valid = 0;
    check_eq("t5_flush_valid", out_valid, 0);
    send_beat(rand64(), 0, ok);
    check_eq("t5_after_idx", out_idx, 0);

    // 6: asynchronous reset mid-beat
    in_valid = 1; in_lane = rand64();
    #6;
    rst = 1;
    #1;
    check_eq("t6_valid", out_valid, 0);
    check_eq("t6_lane", out_lane, 0);
    check_eq("t6_idx", out_idx, 0);
    check_eq("t6_last", out_last, 0);
    check_eq("t6_err", err, 0);
    repeat (2) @(posedge clk);
    #1;
    in_valid = 0; rst = 0;
    send_beat(64'h1, 0, ok);
    check_eq("t6_lane0", out_lane, 64'h1);
    check_eq("t6_idx0", out_idx, 0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
